// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg
//   Shared constants for the bit-serial comparator slice.
//   - ST_*  : FSM state encoding used by serial_cmp_nbit.
//   - RES_* : one-hot result encoding for consumers that pack {gt,eq,lt}.
//   - cnt_width() : bit counter width, max(1, clog2(w)).
package serial_cmp_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cmp_cell_1bit.sv
// cmp_cell_1bit
//   Combinational 1-bit magnitude/equality cell.
//   Ports:
//     x, y : input bits to compare
//     e    : x == y
//     g    : x > y
//     l    : x < y
module cmp_cell_1bit (
  input  logic x,
  input  logic y,
  output logic e,
  output logic g,
  output logic l
);

  assign e = ~(x ^ y);
  assign g = x & ~y;
  assign l = ~x & y;

endmodule

// File: rtl/serial_cmp_nbit.sv
// serial_cmp_nbit
//   Bit-serial WIDTH-bit unsigned comparator. Operands are latched on an
//   accepted start (IDLE only) and scanned MSB-first, one bit per clock.
//   The result flags eq/gt/lt are registered and become valid in the
//   cycle that done pulses; they are held until the next accepted start.
//   Ports:
//     clk   : clock, rising edge
//     rst   : synchronous reset, active-high
//     start : compare request, sampled in IDLE only
//     a, b  : WIDTH-bit operands, sampled on the accepted start
//     busy  : high in COMPARE and DONE
//     done  : one-cycle completion pulse
//     eq/gt/lt : result flags (unsigned)
//   Build option:
//     SERIAL_CMP_EARLY_EXIT_EN - when defined, COMPARE ends on the first
//     differing bit instead of always scanning all WIDTH bits.
module serial_cmp_nbit
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             decided;
  logic             gt_r;
  logic             lt_r;

  logic cell_e;
  logic cell_g;
  logic cell_l;

  logic hit;
  logic decided_nxt;
  logic gt_nxt;
  logic lt_nxt;
  logic last;
  logic finish;

  cmp_cell_1bit u_cell (
    .x (sa[WIDTH-1]),
    .y (sb[WIDTH-1]),
    .e (cell_e),
    .g (cell_g),
    .l (cell_l)
  );

  // Only the first differing bit (from the MSB) decides the ordering;
  // later bits must not overwrite it.
  always_comb begin
    hit         = ~decided & ~cell_e;
    decided_nxt = decided | hit;
    gt_nxt      = hit ? cell_g : gt_r;
    lt_nxt      = hit ? cell_l : lt_r;
    last        = (cnt == '0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish      = last | hit;
`else
    finish      = last;
`endif
  end

  // The result flags are written on the last COMPARE edge, so they are
  // already valid during the DONE cycle when done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa      <= a;
            sb      <= b;
            cnt     <= CW'(WIDTH - 1);
            decided <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            state   <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          sa      <= sa << 1;
          sb      <= sb << 1;
          decided <= decided_nxt;
          gt_r    <= gt_nxt;
          lt_r    <= lt_nxt;
          // Counter stops at zero; it is reloaded on the next start.
          if (!last) begin
            cnt <= cnt - CW'(1);
          end
          if (finish) begin
            eq    <= ~decided_nxt;
            gt    <= gt_nxt;
            lt    <= lt_nxt;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_cmp_nbit.sv
// tb_serial_cmp_nbit
//   Scoreboard bench for serial_cmp_nbit, with a WIDTH=8 and a WIDTH=1
//   instance sharing clock and reset. Each accepted start pushes the
//   expected {gt,eq,lt} and the expected done cycle; a negedge monitor
//   pops and compares whenever done pulses.
//   Honours SERIAL_CMP_EARLY_EXIT_EN for the expected done timing.
module tb_serial_cmp_nbit;
  import serial_cmp_pkg::*;

  typedef struct {
    logic [2:0] res;
    int         when;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, eq8, gt8, lt8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       busy1, done1, eq1, gt1, lt1;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t e8;
  exp_t e1;

  serial_cmp_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
  );

  serial_cmp_nbit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2:0] refResult(input int unsigned x, input int unsigned y);
    if (x > y) return RES_GT;
    if (x == y) return RES_EQ;
    return RES_LT;
  endfunction

  // Number of COMPARE cycles: done is visible right after edge k+steps.
  function automatic int refSteps(input int unsigned x, input int unsigned y, input int w);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = w - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return w - i;
    end
`endif
    return w;
  endfunction

  // Drives a one-cycle start at a negedge; the accepting edge is cyc+1.
  // Operands are scrambled right after the accepting edge.
  task automatic applyStimulus(input bit sel1, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    @(negedge clk);
    if (sel1) begin
      a1 = x[0:0];
      b1 = y[0:0];
      start1 = 1'b1;
      e.res  = refResult(32'(x[0]), 32'(y[0]));
      e.when = cyc + 1 + refSteps(32'(x[0]), 32'(y[0]), 1);
      q1.push_back(e);
    end else begin
      a8 = x;
      b8 = y;
      start8 = 1'b1;
      e.res  = refResult(32'(x), 32'(y));
      e.when = cyc + 1 + refSteps(32'(x), 32'(y), 8);
      q8.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    a8 = ~x;
    b8 = ~y;
    a1 = ~x[0:0];
    b1 = ~y[0:0];
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((q8.size() != 0 || q1.size() != 0 || busy8 || busy1) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) checkOutput({tag, " timeout"}, q8.size() + q1.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done8) begin
        if (q8.size() == 0) begin
          checkOutput("d8 unexpected done", 1, 0);
        end else begin
          e8 = q8.pop_front();
          checkOutput("d8 result", 32'({gt8, eq8, lt8}), 32'(e8.res));
          checkOutput("d8 done edge", cyc, e8.when);
        end
      end
      if (done1) begin
        if (q1.size() == 0) begin
          checkOutput("d1 unexpected done", 1, 0);
        end else begin
          e1 = q1.pop_front();
          checkOutput("d1 result", 32'({gt1, eq1, lt1}), 32'(e1.res));
          checkOutput("d1 done edge", cyc, e1.when);
        end
      end
    end
  end

  initial begin
    int n;
    exp_t e;

    // Reset state and quiet idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset busy8/done8", 32'({busy8, done8}), 0);
    checkOutput("reset flags8", 32'({gt8, eq8, lt8}), 0);
    checkOutput("reset busy1/done1", 32'({busy1, done1}), 0);
    checkOutput("reset flags1", 32'({gt1, eq1, lt1}), 0);
    repeat (4) @(negedge clk);
    checkOutput("idle no start", 32'({busy8, done8, busy1, done1}), 0);

    // Equal operands, then flags held while idle
    applyStimulus(0, 8'hA5, 8'hA5);
    checkOutput("busy after start", 32'(busy8), 1);
    checkOutput("flags clear while busy", 32'({gt8, eq8, lt8}), 0);
    waitIdle("eq A5");
    repeat (3) @(negedge clk);
    checkOutput("eq held idle", 32'({gt8, eq8, lt8}), 32'(RES_EQ));

    // MSB mismatch (early exit candidate)
    applyStimulus(0, 8'h80, 8'h7F);
    waitIdle("gt 80/7F");
    checkOutput("gt held idle", 32'({gt8, eq8, lt8}), 32'(RES_GT));

    // LSB-only mismatch, extra start while busy must be ignored
    applyStimulus(0, 8'h10, 8'h11);
    repeat (3) @(negedge clk);
    a8 = 8'hFF;
    b8 = 8'h00;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitIdle("lt 10/11");
    repeat (2) @(negedge clk);
    checkOutput("no restart after ignored start", 32'(busy8), 0);

    // Reset in the middle of COMPARE aborts without a done pulse
    applyStimulus(0, 8'h3C, 8'h3C);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", 32'(busy8), 0);
    checkOutput("abort flags", 32'({gt8, eq8, lt8}), 0);
    repeat (10) @(negedge clk);
    checkOutput("abort no done later", 32'({busy8, done8}), 0);
    applyStimulus(0, 8'd3, 8'd3);
    waitIdle("eq after abort");

    // Back-to-back: start held through DONE, accepted on the first IDLE edge
    applyStimulus(0, 8'd1, 8'd2);
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) checkOutput("b2b first done wait", 0, 1);
    a8 = 8'd2;
    b8 = 8'd1;
    start8 = 1'b1;
    e.res  = RES_GT;
    e.when = cyc + 2 + refSteps(32'd2, 32'd1, 8);
    q8.push_back(e);
    repeat (2) @(negedge clk);
    start8 = 1'b0;
    waitIdle("b2b");

    // Single-bit instance
    applyStimulus(1, 8'd1, 8'd0);
    waitIdle("w1 gt");
    applyStimulus(1, 8'd0, 8'd1);
    waitIdle("w1 lt");
    applyStimulus(1, 8'd1, 8'd1);
    waitIdle("w1 eq");
    checkOutput("w1 eq held", 32'({gt1, eq1, lt1}), 32'(RES_EQ));

    // A few random compares on the wide instance
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      waitIdle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_cmp_nbit.md
Name: serial_cmp_nbit

Overview:
- Bit-serial N-bit magnitude/equality comparator; sequential counterpart of the team's combinational 1-bit comparator cell.
- Latches two WIDTH-bit words on a start handshake and scans them MSB-first, one bit per clock.
- Reports eq/gt/lt with a one-cycle done pulse.
- Sits after any datapath that needs a low-area compare, and serves as the workshop's first FSM-plus-datapath exercise.

Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to compare a and b; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepted start edge only.
- b  input  WIDTH  operand B; sampled on the accepted start edge only.
- busy  output  1  high in COMPARE and DONE.
- done  output  1  one-cycle pulse; eq/gt/lt are valid from this cycle on.
- eq  output  1  A == B.
- gt  output  1  A > B, unsigned.
- lt  output  1  A < B, unsigned.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
- Reset state:
  - FSM goes to IDLE.
  - busy=0, done=0, eq=0, gt=0, lt=0.
  - Shift registers, bit counter and decided flag clear to 0.
  - Reset asserted mid-COMPARE or in DONE aborts the operation, with no done pulse.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - If start=1 at edge k: load sa<=a, sb<=b, cnt<=WIDTH-1, decided<=0, eq/gt/lt<=0, go to COMPARE.
  - Otherwise hold. Previous results stay held.
- COMPARE, one cycle per bit, using msb_a=sa[WIDTH-1] and msb_b=sb[WIDTH-1]:
  - If decided=0 and msb_a!=msb_b: decided<=1, gt_r<=msb_a, lt_r<=msb_b.
  - Each cycle: sa, sb shift left by 1 with zero fill; cnt decrements.
  - When cnt==0, this is the last bit: go to DONE.
- DONE, exactly one cycle:
  - done=1.
  - eq<=~decided (including the final-bit update), gt<=gt_r, lt<=lt_r.
  - Then return to IDLE.
- Result flags:
  - Exactly one of eq/gt/lt is 1 from the done cycle until the next accepted start.
  - All three are 0 while busy.
- Start handling:
  - start is ignored while busy, including in DONE.
  - A start in the cycle after done (IDLE) is accepted, so back-to-back throughput is WIDTH+2 cycles per compare.
- Latency without early exit: start accepted at edge k; COMPARE in cycles k+1..k+WIDTH; done high in cycle k+WIDTH+1.
- WIDTH=1: a single COMPARE cycle.
- Counter width is max(1, clog2(WIDTH)). No wrap-around beyond 0 is ever reached.
- a and b may change freely after the accepted start; results depend only on the latched values.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - COMPARE goes to DONE in the same cycle that the first mismatch is detected.
  - For a mismatch at bit i (MSB=WIDTH-1), done is high in cycle k+(WIDTH-i)+1.
  - Equal operands still take the full WIDTH+1 cycles.
- Undefined: fixed latency of WIDTH+1 cycles regardless of data, as described above.
- Result values are identical in both builds; only timing differs.

Decomposition:
- Shared package serial_cmp_pkg holds:
  - FSM state encoding constants ST_IDLE=2'd0, ST_COMPARE=2'd1, ST_DONE=2'd2.
  - Result encoding constants for any consumer that packs {gt,eq,lt}.
- One sub-module is natural: cmp_cell_1bit.
  - Purely combinational, inputs x, y.
  - Outputs e=x XNOR y, g=x&~y, l=~x&y.
  - Instantiated once on the shifted MSBs to drive the decided/gt_r/lt_r update.
- FSM, counter and shift registers stay in serial_cmp_nbit.

Test Plan:
1. WIDTH=8, reset held 2 cycles then released -> busy=0, done=0, eq=gt=lt=0; no activity without start.
2. a=8'hA5, b=8'hA5, start for 1 cycle at edge k -> busy from k+1; done=1 only in cycle k+9; eq=1, gt=0, lt=0, held while idle.
3. a=8'h80, b=8'h7F -> gt=1, eq=0, lt=0. Without the macro, done at k+9; with SERIAL_CMP_EARLY_EXIT_EN, done at k+2.
4. a=8'h10, b=8'h11 (mismatch only at LSB) -> lt=1, done at k+9 in both builds. Start pulsed again at k+4 is ignored (no extra done, a/b changes ignored).
5. Start a compare, assert rst at k+3 for 1 cycle -> busy=0 and all flags 0 on the next cycle, no done pulse. A new start afterwards (a=3, b=3) completes normally with eq=1.
6. Back-to-back: start at k (a=1, b=2), start again at the first IDLE cycle k+10 (a=2, b=1) -> first done gives lt=1, second done at k+19 gives gt=1. Repeat with WIDTH=1, a=1, b=0 -> done at k+2, gt=1.
